// File: rtl/div_pkg.sv
// Shared types for the divider issue stage: FSM state encoding and the result record.
package div_pkg;

    localparam int DIV_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } div_state_e;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] q;
        logic                 dvz;
        logic                 ovf;
        logic                 tmo;
    } div_result_t;

    function automatic div_result_t mk_result(
        input logic [DIV_WIDTH-1:0] q,
        input logic                 dvz,
        input logic                 ovf,
        input logic                 tmo
    );
        div_result_t r;
        r.q   = q;
        r.dvz = dvz;
        r.ovf = ovf;
        r.tmo = tmo;
        return r;
    endfunction

endpackage

// File: rtl/div_op_fifo.sv
// Operand FIFO: first-word fall-through read, power-of-two depth so pointers wrap naturally.
module div_op_fifo #(
    parameter  int DW    = 20,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          push_s;
    logic          pop_s;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == {CW{1'b0}});
    assign push_s  = push_i & ~full_o;
    assign pop_s   = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Occupancy next-state: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue stage for the sequential divider: buffers operand pairs, runs one division at a time,
// resolves zero divisors and hung divisions locally, and returns results over valid/ready.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     div_start,
    output logic [WIDTH-1:0]         div_a,
    output logic [WIDTH-1:0]         div_b,
    input  logic                     div_done,
    input  logic [WIDTH-1:0]         div_q,
    input  logic                     div_ovf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_q,
    output logic                     out_dvz,
    output logic                     out_ovf,
    output logic                     out_tmo,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT);

    div_state_e        state_q;
    div_state_e        state_d;
    logic [WIDTH-1:0]  div_a_q;
    logic [WIDTH-1:0]  div_a_d;
    logic [WIDTH-1:0]  div_b_q;
    logic [WIDTH-1:0]  div_b_d;
    logic [TW-1:0]     tmo_cnt_q;
    logic [TW-1:0]     tmo_cnt_d;
    div_result_t       res_q;
    div_result_t       res_d;

    logic              push_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [2*WIDTH-1:0] fifo_rdata_s;
    logic [WIDTH-1:0]  pop_a_s;
    logic [WIDTH-1:0]  pop_b_s;
    logic [CW-1:0]     fifo_count_s;

    assign in_ready   = ~fifo_full_s;
    assign push_s     = in_valid & in_ready;
    assign pop_a_s    = fifo_rdata_s[2*WIDTH-1:WIDTH];
    assign pop_b_s    = fifo_rdata_s[WIDTH-1:0];
    assign fifo_count = fifo_count_s;

    div_op_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i ({in_a, in_b}),
        .rdata_o (fifo_rdata_s),
        .count_o (fifo_count_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // State, operand, timeout and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_a_q   <= {WIDTH{1'b0}};
            div_b_q   <= {WIDTH{1'b0}};
            tmo_cnt_q <= {TW{1'b0}};
            res_q     <= mk_result({DIV_WIDTH{1'b0}}, 1'b0, 1'b0, 1'b0);
        end else begin
            state_q   <= state_d;
            div_a_q   <= div_a_d;
            div_b_q   <= div_b_d;
            tmo_cnt_q <= tmo_cnt_d;
            res_q     <= res_d;
        end
    end

    // Next-state and datapath capture; out_valid is only high in OUT, so IDLE pops freely.
    always_comb begin
        state_d   = state_q;
        div_a_d   = div_a_q;
        div_b_d   = div_b_q;
        tmo_cnt_d = tmo_cnt_q;
        res_d     = res_q;
        pop_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    if (pop_b_s == {WIDTH{1'b0}}) begin
                        res_d   = mk_result({DIV_WIDTH{1'b0}}, 1'b1, 1'b0, 1'b0);
                        state_d = OUT;
                    end else begin
                        div_a_d = pop_a_s;
                        div_b_d = pop_b_s;
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                tmo_cnt_d = {TW{1'b0}};
                state_d   = WAIT;
            end
            WAIT: begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
                if (div_done) begin
                    res_d   = mk_result(div_q, 1'b0, div_ovf, 1'b0);
                    state_d = OUT;
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    res_d   = mk_result({DIV_WIDTH{1'b0}}, 1'b0, 1'b0, 1'b1);
                    state_d = OUT;
                end else begin
                    state_d = WAIT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode straight from the state register.
    always_comb begin
        div_start = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
            end
            ISSUE: begin
                div_start = 1'b1;
                busy      = 1'b1;
            end
            WAIT: begin
                busy = 1'b1;
            end
            OUT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign div_a   = div_a_q;
    assign div_b   = div_b_q;
    assign out_q   = res_q.q;
    assign out_dvz = res_q.dvz;
    assign out_ovf = res_q.ovf;
    assign out_tmo = res_q.tmo;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: vector table for single divisions plus queueing/reset sequences.
module tb_div_issue_ctrl;

    localparam int W       = 10;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         div_start;
    logic [W-1:0] div_a;
    logic [W-1:0] div_b;
    logic         div_done;
    logic [W-1:0] div_q;
    logic         div_ovf;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_q;
    logic         out_dvz;
    logic         out_ovf;
    logic         out_tmo;
    logic         busy;
    logic [2:0]   fifo_count;

    int total = 0;
    int bad   = 0;

    // divider model controls (written by main), model state (written by model)
    int           model_lat  = 0;
    logic         model_ovf  = 1'b0;
    int           kick_cyc   = -1;
    int           mcyc       = 0;
    int           mcnt       = 0;
    logic [W-1:0] mq         = '0;
    logic         movf_l     = 1'b0;
    logic [W-1:0] got[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        logic         movf;
        logic [W-1:0] eq;
        logic         edvz;
        logic         eovf;
        logic         etmo;
        int           estarts;
        int           elat;
    } vec_t;

    vec_t vecs[7];

    div_issue_ctrl #(.WIDTH(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_done   (div_done),
        .div_q      (div_q),
        .div_ovf    (div_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_q      (out_q),
        .out_dvz    (out_dvz),
        .out_ovf    (out_ovf),
        .out_tmo    (out_tmo),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Divider model: done pulse model_lat cycles after the start cycle; kick_cyc forces a stray done.
    initial begin
        div_done = 1'b0;
        div_q    = '0;
        div_ovf  = 1'b0;
        forever begin
            @(negedge clk);
            mcyc     = mcyc + 1;
            div_done = 1'b0;
            if (rst) begin
                mcnt = 0;
            end else if (mcnt != 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0) begin
                    div_done = 1'b1;
                    div_q    = mq;
                    div_ovf  = movf_l;
                end
            end
            if (mcyc == kick_cyc) begin
                div_done = 1'b1;
                div_q    = 10'd77;
                div_ovf  = 1'b1;
            end
            if (div_start && model_lat != 0) begin
                mcnt   = model_lat;
                mq     = div_a / div_b;
                movf_l = model_ovf;
            end
        end
    end

    // Result monitor: records every accepted result.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) got.push_back(out_q);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_seq(input logic [W-1:0] as[], input logic [W-1:0] bs[], output int acc);
        acc = 0;
        for (int k = 0; k < as.size(); k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = as[k];
            in_b     = bs[k];
            if (in_ready) acc = acc + 1;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic apply(input int idx, input vec_t v);
        int           n;
        int           starts;
        logic [W-1:0] ca;
        logic [W-1:0] cb;
        model_lat = v.lat;
        model_ovf = v.movf;
        starts    = 0;
        ca        = '0;
        cb        = '0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        @(negedge clk);
        in_valid = 1'b0;
        n        = 1;
        while (!out_valid && n < 200) begin
            if (div_start) begin
                starts = starts + 1;
                ca     = div_a;
                cb     = div_b;
            end
            @(negedge clk);
            n = n + 1;
        end
        chk($sformatf("v%0d_valid", idx), out_valid, 1);
        chk($sformatf("v%0d_latency", idx), n, v.elat);
        chk($sformatf("v%0d_starts", idx), starts, v.estarts);
        if (v.estarts != 0) begin
            chk($sformatf("v%0d_div_a", idx), ca, v.a);
            chk($sformatf("v%0d_div_b", idx), cb, v.b);
        end
        chk($sformatf("v%0d_q", idx), out_q, v.eq);
        chk($sformatf("v%0d_dvz", idx), out_dvz, v.edvz);
        chk($sformatf("v%0d_ovf", idx), out_ovf, v.eovf);
        chk($sformatf("v%0d_tmo", idx), out_tmo, v.etmo);
        @(negedge clk);
        chk($sformatf("v%0d_cleared", idx), {out_valid, busy}, 2'b00);
    endtask

    initial begin
        int           n;
        int           acc;
        int           base;
        logic [W-1:0] as[];
        logic [W-1:0] bs[];
        logic [W-1:0] eq[];

        //           a        b       lat movf  q        dvz   ovf   tmo   starts lat
        vecs[0] = '{10'd100,  10'd7,  12, 1'b0, 10'd14,  1'b0, 1'b0, 1'b0, 1, 15};
        vecs[1] = '{10'd55,   10'd0,   5, 1'b0, 10'd0,   1'b1, 1'b0, 1'b0, 0, 2};
        vecs[2] = '{10'd1023, 10'd3,   1, 1'b0, 10'd341, 1'b0, 1'b0, 1'b0, 1, 4};
        vecs[3] = '{10'd900,  10'd1,   0, 1'b0, 10'd0,   1'b0, 1'b0, 1'b1, 1, 35};
        vecs[4] = '{10'd512,  10'd2,   3, 1'b1, 10'd256, 1'b0, 1'b1, 1'b0, 1, 6};
        vecs[5] = '{10'd0,    10'd5,   2, 1'b0, 10'd0,   1'b0, 1'b0, 1'b0, 1, 5};
        vecs[6] = '{10'd0,    10'd0,   2, 1'b0, 10'd0,   1'b1, 1'b0, 1'b0, 0, 2};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_outs", {out_valid, busy, div_start, out_dvz, out_ovf, out_tmo}, 6'd0);
        chk("rst_count", fifo_count, 0);
        chk("rst_data", {div_a, div_b, out_q}, 30'd0);

        for (int i = 0; i < 7; i++) apply(i, vecs[i]);

        // back-to-back pushes with the consumer stalled
        out_ready = 1'b0;
        model_lat = 2;
        model_ovf = 1'b0;
        base      = got.size();
        as = '{10'd40, 10'd63, 10'd90, 10'd77, 10'd200, 10'd36};
        bs = '{10'd2,  10'd3,  10'd9,  10'd7,  10'd8,   10'd3};
        eq = '{10'd20, 10'd21, 10'd10, 10'd11, 10'd25};
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("q_count_le4_%0d", k), (fifo_count <= 3'd4), 1);
            in_valid = 1'b1;
            in_a     = as[k];
            in_b     = bs[k];
            if (in_ready) acc = acc + 1;
            if (k == 5) chk("q_in_ready_full", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("q_accepted", acc, 5);
        chk("q_count_full", fifo_count, 4);
        chk("q_held_valid", out_valid, 1);
        chk("q_held_q", out_q, 20);
        out_ready = 1'b1;
        n = 0;
        while (got.size() < base + 5 && n < 300) begin
            @(negedge clk);
            n = n + 1;
        end
        repeat (10) @(negedge clk);
        chk("q_drained", got.size() - base, 5);
        chk("q_count_empty", fifo_count, 0);
        for (int k = 0; k < 5; k++) begin
            if (base + k < got.size()) chk($sformatf("q_order_%0d", k), got[base + k], eq[k]);
        end

        // reset while waiting on the divider with two entries queued
        model_lat = 0;
        as = '{10'd100, 10'd30, 10'd44};
        bs = '{10'd5,   10'd3,  10'd4};
        push_seq(as, bs, acc);
        chk("r_busy_wait", {busy, div_start}, 2'b10);
        chk("r_count_pre", fifo_count, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("r_count", fifo_count, 0);
        chk("r_flags", {out_valid, busy, in_ready}, 3'b001);
        base     = got.size();
        kick_cyc = mcyc + 2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("r_ignore_done_%0d", k), {out_valid, busy, fifo_count}, 5'd0);
        end
        chk("r_no_result", got.size() - base, 0);
        apply(7, vecs[0]);

        // push during the pop cycle at count=2, then wrap the pointers
        out_ready = 1'b0;
        model_lat = 1;
        base      = got.size();
        as = '{10'd11, 10'd24, 10'd39};
        bs = '{10'd1,  10'd2,  10'd3};
        push_seq(as, bs, acc);
        @(negedge clk);
        @(negedge clk);
        chk("w_hold", {out_valid, fifo_count}, 4'b1010);
        out_ready = 1'b1;
        @(negedge clk);
        chk("w_idle_cnt2", {busy, fifo_count}, 4'b0010);
        in_valid = 1'b1;
        in_a     = 10'd56;
        in_b     = 10'd4;
        @(negedge clk);
        in_valid = 1'b0;
        chk("w_push_pop_cnt", fifo_count, 2);
        chk("w_busy_after_pop", busy, 1);
        as = '{10'd75, 10'd96};
        bs = '{10'd5,  10'd6};
        push_seq(as, bs, acc);
        chk("w_late_accepted", acc, 2);
        n = 0;
        while (got.size() < base + 6 && n < 300) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("w_drained", got.size() - base, 6);
        eq = '{10'd11, 10'd12, 10'd13, 10'd14, 10'd15, 10'd16};
        for (int k = 0; k < 6; k++) begin
            if (base + k < got.size()) chk($sformatf("w_order_%0d", k), got[base + k], eq[k]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
